// File: rtl/fft_result_reorder.sv
// Reorders one frame of bit-reversed FFT results into natural bin order.
// Two banks ping-pong: one fills from the FFT while the other drains downstream.
module fft_result_reorder #(
    parameter int unsigned N         = 8,
    parameter int unsigned RES_WIDTH = 11,
    localparam int unsigned LOG2N    = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic                 in_sop,
    input  logic [RES_WIDTH-1:0] in_re,
    input  logic [RES_WIDTH-1:0] in_im,
    output logic                 in_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [RES_WIDTH-1:0] out_re,
    output logic [RES_WIDTH-1:0] out_im,
    output logic [LOG2N-1:0]     out_index,
    output logic                 out_last,
    output logic                 overflow,
    output logic                 frame_err
);

    typedef enum logic [1:0] {StIdle, StFetch, StStream} state_e;

    localparam logic [LOG2N-1:0] LastIdx = LOG2N'(N - 1);

    state_e                 state_q, state_d;
    logic [1:0]             full_q, full_d;
    logic                   wr_bank_q, wr_bank_d;
    logic [LOG2N-1:0]       wr_ptr_q, wr_ptr_d;
    logic                   rd_bank_q, rd_bank_d;
    logic [LOG2N-1:0]       out_index_q, out_index_d;
    logic [RES_WIDTH-1:0]   out_re_q, out_re_d;
    logic [RES_WIDTH-1:0]   out_im_q, out_im_d;
    logic                   overflow_q, overflow_d;
    logic                   frame_err_q, frame_err_d;

    logic [RES_WIDTH-1:0]   mem_re [2*N];
    logic [RES_WIDTH-1:0]   mem_im [2*N];

    logic                   wr_en;
    logic                   wr_set;
    logic [LOG2N-1:0]       wr_j;
    logic [LOG2N:0]         wr_addr;
    logic                   rd_clr;
    logic                   other_full;
    logic [LOG2N-1:0]       rd_next;

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < int'(LOG2N); i++) begin
            r[i] = a[int'(LOG2N) - 1 - i];
        end
        return r;
    endfunction

    // Write side: accept, scatter to bit-reversed address, mark bank full on last word.
    always_comb begin
        in_ready    = !full_q[wr_bank_q];
        wr_en       = in_valid && in_ready;
        // A start-of-frame always restarts the frame at j = 0.
        wr_j        = in_sop ? '0 : wr_ptr_q;
        wr_addr     = {wr_bank_q, bitrev(wr_j)};
        wr_set      = wr_en && (wr_j == LastIdx);
        wr_ptr_d    = wr_ptr_q;
        wr_bank_d   = wr_bank_q;
        overflow_d  = in_valid && !in_ready;
        frame_err_d = wr_en && in_sop && (wr_ptr_q != '0);
        if (wr_en) begin
            if (wr_set) begin
                wr_ptr_d  = '0;
                wr_bank_d = !wr_bank_q;
            end else begin
                wr_ptr_d  = wr_j + 1'b1;
            end
        end
    end

    // Read FSM: fetch bin 0 into the output register, then stream with handshake.
    always_comb begin
        state_d     = state_q;
        rd_bank_d   = rd_bank_q;
        out_index_d = out_index_q;
        out_re_d    = out_re_q;
        out_im_d    = out_im_q;
        rd_clr      = 1'b0;
        rd_next     = out_index_q + 1'b1;
        // Include a fill completing this very edge so a back-to-back frame skips IDLE.
        other_full  = full_q[!rd_bank_q] || (wr_set && (wr_bank_q != rd_bank_q));
        unique case (state_q)
            StIdle: begin
                if (full_q[rd_bank_q]) state_d = StFetch;
            end
            StFetch: begin
                out_index_d = '0;
                out_re_d    = mem_re[{rd_bank_q, LOG2N'(0)}];
                out_im_d    = mem_im[{rd_bank_q, LOG2N'(0)}];
                state_d     = StStream;
            end
            StStream: begin
                if (out_ready) begin
                    if (out_index_q == LastIdx) begin
                        rd_clr    = 1'b1;
                        rd_bank_d = !rd_bank_q;
                        state_d   = other_full ? StFetch : StIdle;
                    end else begin
                        out_index_d = rd_next;
                        out_re_d    = mem_re[{rd_bank_q, rd_next}];
                        out_im_d    = mem_im[{rd_bank_q, rd_next}];
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Bank full flags: set by a completed fill, cleared by a completed drain.
    always_comb begin
        full_d = full_q;
        if (wr_set) full_d[wr_bank_q] = 1'b1;
        if (rd_clr) full_d[rd_bank_q] = 1'b0;
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            full_q      <= '0;
            wr_bank_q   <= 1'b0;
            wr_ptr_q    <= '0;
            rd_bank_q   <= 1'b0;
            out_index_q <= '0;
            out_re_q    <= '0;
            out_im_q    <= '0;
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            full_q      <= full_d;
            wr_bank_q   <= wr_bank_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_bank_q   <= rd_bank_d;
            out_index_q <= out_index_d;
            out_re_q    <= out_re_d;
            out_im_q    <= out_im_d;
            overflow_q  <= overflow_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Buffer storage; contents are only ever read from a bank flagged full.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_re[wr_addr] <= in_re;
            mem_im[wr_addr] <= in_im;
        end
    end

    // Output drive.
    always_comb begin
        out_valid = (state_q == StStream);
        out_last  = out_valid && (out_index_q == LastIdx);
        out_re    = out_re_q;
        out_im    = out_im_q;
        out_index = out_index_q;
        overflow  = overflow_q;
        frame_err = frame_err_q;
    end

endmodule

// File: tb/tb_fft_result_reorder.sv
// Bench for fft_result_reorder: directed scenarios with random data, scored against
// a frame-level model (arrival queue -> natural-order expected queue).
module tb_fft_result_reorder;

    localparam int N     = 8;
    localparam int W     = 11;
    localparam int LOG2N = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid, in_sop, in_ready;
    logic [W-1:0]     in_re, in_im;
    logic             out_valid, out_ready, out_last, overflow, frame_err;
    logic [W-1:0]     out_re, out_im;
    logic [LOG2N-1:0] out_index;

    always #5 clk = ~clk;

    fft_result_reorder #(.N(N), .RES_WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_sop    (in_sop),
        .in_re     (in_re),
        .in_im     (in_im),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_re    (out_re),
        .out_im    (out_im),
        .out_index (out_index),
        .out_last  (out_last),
        .overflow  (overflow),
        .frame_err (frame_err)
    );

    typedef struct packed {
        logic [W-1:0]     re;
        logic [W-1:0]     im;
        logic [LOG2N-1:0] idx;
        logic             last;
    } exp_t;

    exp_t           exp_q[$];
    logic [2*W-1:0] cur_q[$];

    int checks = 0, failures = 0;
    int cyc = 0, held = 0;
    int exp_ovf = 0, exp_ferr = 0, dut_ovf = 0, dut_ferr = 0;
    int last_in_cyc = 0, last_acc_cyc = 0, rise_cyc = 0, last_gap = 0, low_run = 1000;
    logic prev_valid = 1'b0, hold = 1'b0;
    logic [W-1:0]     hold_re, hold_im;
    logic [LOG2N-1:0] hold_idx;

    logic             s_out_valid, s_in_ready, s_ovf, s_ferr, s_last;
    logic [W-1:0]     s_re, s_im;
    logic [LOG2N-1:0] s_idx;

    function automatic int brev(input int j);
        int r = 0;
        for (int b = 0; b < LOG2N; b++) if (((j >> b) & 1) != 0) r |= 1 << (LOG2N - 1 - b);
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        cur_q.delete();
        held = 0;
        hold = 1'b0;
    endtask

    // One clock: sample and score at the falling edge, return just after the rising edge.
    task automatic tick();
        exp_t e;
        logic [2*W-1:0] w;
        @(negedge clk);
        cyc++;
        s_out_valid = out_valid; s_in_ready = in_ready; s_ovf = overflow; s_ferr = frame_err;
        s_re = out_re; s_im = out_im; s_idx = out_index; s_last = out_last;
        if (!rst) begin
            if (hold) begin
                check("hold_valid", out_valid, 1);
                check("hold_re", out_re, hold_re);
                check("hold_im", out_im, hold_im);
                check("hold_idx", out_index, hold_idx);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", out_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_re", out_re, e.re);
                    check("out_im", out_im, e.im);
                    check("out_index", out_index, e.idx);
                    check("out_last", out_last, e.last);
                    if (e.last) begin
                        last_acc_cyc = cyc;
                        held--;
                    end
                end
            end
            hold = out_valid && !out_ready;
            hold_re = out_re; hold_im = out_im; hold_idx = out_index;
            if (in_valid) begin
                check("in_ready", in_ready, (held - (out_valid && out_ready && out_last ? -1 : 0)
                      < 2) ? 1 : 0);
            end
            if (overflow) dut_ovf++;
            if (frame_err) dut_ferr++;
        end else begin
            hold = 1'b0;
        end
        if (out_valid && !prev_valid) begin
            last_gap = low_run;
            rise_cyc = cyc;
        end
        low_run = out_valid ? 0 : low_run + 1;
        prev_valid = out_valid;
        @(posedge clk);
        #1;
    endtask

    // Write-side model, applied to the words sent in the tick just completed.
    task automatic model_write(input int re, input int im, input bit sop, input int held_before);
        logic [2*W-1:0] w;
        exp_t e;
        if (held_before < 2) begin
            if (sop && cur_q.size() != 0) begin
                exp_ferr++;
                cur_q.delete();
            end
            cur_q.push_back({W'(re), W'(im)});
            if (cur_q.size() == N) begin
                for (int k = 0; k < N; k++) begin
                    w = cur_q[brev(k)];
                    e.re = w[2*W-1:W];
                    e.im = w[W-1:0];
                    e.idx = LOG2N'(k);
                    e.last = (k == N - 1);
                    exp_q.push_back(e);
                end
                cur_q.delete();
                held++;
                last_in_cyc = cyc;
            end
        end else begin
            exp_ovf++;
        end
    endtask

    task automatic send_word(input int re, input int im, input bit sop);
        int hb;
        in_valid = 1'b1; in_sop = sop; in_re = W'(re); in_im = W'(im);
        // Bank occupancy as seen by this word: a drain finishing on the same edge frees
        // its bank only from the next cycle on.
        hb = held;
        tick();
        model_write(re, im, sop, hb);
        in_valid = 1'b0; in_sop = 1'b0;
    endtask

    task automatic send_rand_frame();
        for (int j = 0; j < N; j++) send_word(int'($urandom()), int'($urandom()), j == 0);
    endtask

    task automatic drain(input int max);
        for (int i = 0; i < max && exp_q.size() != 0; i++) tick();
        check("drain_empty", exp_q.size(), 0);
        for (int i = 0; i < 3; i++) tick();
    endtask

    int t1[8] = '{0, 4, 2, 6, 1, 5, 3, 7};
    int pat[4] = '{1, 0, 0, 1};
    int base, c0;
    bit found;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_sop = 1'b0; in_re = '0; in_im = '0; out_ready = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();
        check("rst_out_valid", s_out_valid, 0);
        check("rst_in_ready", s_in_ready, 1);
        check("rst_out_re", s_re, 0);
        check("rst_out_index", s_idx, 0);
        check("rst_out_last", s_last, 0);
        check("rst_pulses", {s_ovf, s_ferr}, 0);

        // 1: single frame, known pattern, latency and no bubbles.
        for (int j = 0; j < N; j++) send_word(t1[j], 10 * t1[j], j == 0);
        c0 = last_in_cyc;
        drain(40);
        check("t1_latency", rise_cyc - c0, 3);
        check("t1_no_bubble", last_acc_cyc - rise_cyc, N - 1);

        // 2: backpressure pattern 1,0,0,1.
        send_rand_frame();
        for (int i = 0; i < 80 && exp_q.size() != 0; i++) begin
            out_ready = pat[i % 4][0];
            tick();
        end
        out_ready = 1'b1;
        drain(10);

        // 3: three frames with the sink stalled; the third is dropped word by word.
        base = dut_ovf;
        out_ready = 1'b0;
        send_rand_frame(); send_rand_frame(); send_rand_frame();
        check("t3_in_ready_low", s_in_ready, 0);
        out_ready = 1'b1;
        drain(60);
        check("t3_overflows", dut_ovf - base, 8);
        check("t3_gap", last_gap, 1);

        // 4: partial frame then a restart with in_sop.
        base = dut_ferr;
        for (int j = 0; j < 3; j++) send_word(int'($urandom()), int'($urandom()), j == 0);
        send_word(0, int'($urandom()), 1'b1);
        for (int j = 1; j < N; j++) send_word(int'($urandom()), int'($urandom()), 1'b0);
        drain(40);
        check("t4_frame_err", dut_ferr - base, 1);

        // 5: reset while the 4th output word is presented.
        send_rand_frame();
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (s_out_valid && s_idx == 2) begin
                found = 1'b1;
                break;
            end
        end
        check("t5_sync", found, 1);
        rst = 1'b1;
        tick();
        check("t5_4th_word", s_idx, 3);
        rst = 1'b0;
        model_reset();
        tick();
        check("t5_valid", s_out_valid, 0);
        check("t5_ready", s_in_ready, 1);
        check("t5_pulses", {s_ovf, s_ferr}, 0);
        for (int i = 0; i < 4; i++) tick();
        send_rand_frame();
        drain(40);

        // 6: frame 2 completes on the same edge frame 1's last word is accepted.
        send_rand_frame();
        tick(); tick();
        send_rand_frame();
        check("t6_coincide", last_acc_cyc, last_in_cyc);
        for (int j = 0; j < N; j++) begin
            send_word(int'($urandom()), int'($urandom()), j == 0);
            if (j == 0) begin
                check("t6_gap_low", s_out_valid, 0);
                check("t6_f3_ready", s_in_ready, 1);
            end
            if (j == 1) check("t6_stream", s_out_valid, 1);
        end
        drain(60);

        check("total_overflow", dut_ovf, exp_ovf);
        check("total_frame_err", dut_ferr, exp_ferr);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
